regbank_writeback: RTL and testbench
====================================

// Module: regbank_writeback
// PURPOSE
//  Result-side feeder for the regbank write port (write_enable/addr_z/data_z).
//  Buffers results from execute in a DEPTH-entry in-order FIFO with a
//  valid/ready handshake. Drains one entry per cycle into the register bank.
//  Forwards the newest pending value for two read addresses, so operand
//  fetch sees results not yet written into regbank.
// PARAMETERS
//  WIDTH    `WIDTH    data word width
//  REG_SEL  `REG_SEL  register address width
//  DEPTH    4         FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1        clock; all state on rising edge
//  reset        in   1        asynchronous, active-low reset
//  in_valid     in   1        producer has a result
//  in_ready     out  1        FIFO can accept (= !full)
//  in_addr      in   REG_SEL  destination register
//  in_data      in   WIDTH    result value
//  hold         in   1        1 = do not drain this cycle (port owned elsewhere)
//  write_enable out  1        regbank write strobe (registered)
//  addr_z       out  REG_SEL  regbank write address (registered)
//  data_z       out  WIDTH    regbank write data (registered)
//  look_addr_a  in   REG_SEL  forwarding lookup address A
//  look_addr_b  in   REG_SEL  forwarding lookup address B
//  hit_a/hit_b  out  1        pending write exists for look_addr_a/b
//  fwd_a/fwd_b  out  WIDTH    newest pending value for that address (0 if no hit)
//  count        out  log2(DEPTH)+1  occupied FIFO entries
// BEHAVIOUR
//  - reset low (async): rd/wr pointers=0, count=0, write_enable=0,
//    addr_z=0, data_z=0. FIFO storage is not cleared; stale entries are masked.
//  - Push: on an edge with in_valid && in_ready, {in_addr,in_data} is written
//    at wr_ptr and wr_ptr advances mod DEPTH.
//    in_ready comes from registered count only; it is 0 when count==DEPTH,
//    even if a pop happens the same cycle (no pass-through).
//  - Pop: on each edge with count!=0 && !hold, the head moves into
//    addr_z/data_z, write_enable<=1, and rd_ptr advances mod DEPTH.
//    Otherwise write_enable<=0 and addr_z/data_z hold their values.
//  - Push and pop on the same edge: count unchanged, both pointers advance.
//  - Latency: result accepted at edge N with FIFO empty and hold=0 gives
//    write_enable=1 after edge N+1, for exactly one cycle per entry.
//  - Ordering: strictly FIFO. Repeated writes to one address drain in order.
//  - Forwarding (combinational): search the valid FIFO entries plus the output
//    stage (when write_enable=1). Output stage is oldest; FIFO tail is newest.
//    The youngest match wins. No match: hit=0, fwd=0.
//  - Lookup ignores in_* of the current cycle; an entry is visible once pushed.
//  - reset asserted mid-drain: pending entries are discarded and write_enable
//    drops immediately (async). No partial write is issued after reset
//    deasserts.
// TESTING (WIDTH=16, REG_SEL=3, DEPTH=4)
//  1 push {2,0x0004}, hold=0 -> next cycle write_enable=1, addr_z=2, data_z=4;
//    following cycle write_enable=0, count=0
//  2 hold=1, push {0,1},{1,2},{2,3},{3,4} -> count=4, in_ready=0, 5th push
//    ignored; hold=0 -> 4 consecutive writes in order addr 0..3, then in_ready=1
//  3 hold=1, push {1,7} then {1,9}, look_addr_a=1 -> hit_a=1, fwd_a=9;
//    look_addr_b=5 -> hit_b=0, fwd_b=0
//  4 full FIFO, hold=0 and in_valid=1 same edge -> no accept that edge;
//    next edge accepts, count stays 3->3 while draining
//  5 wrap: 6 push/pop pairs through DEPTH=4 -> addresses and data leave
//    in issue order across pointer wrap
//  6 3 entries queued, reset low mid-drain -> write_enable=0 at once, count=0,
//    hit_a=0; after reset high no writes occur until a new push

Source files
------------

// File: rtl/regbank_writeback_if.sv
// regbank_writeback_if: producer-to-writeback result handshake (valid/ready plus register address and data).
interface regbank_writeback_if #(
   parameter int WIDTH   = 16,
   parameter int REG_SEL = 3
);
   logic               in_valid;
   logic               in_ready;
   logic [REG_SEL-1:0] in_addr;
   logic [WIDTH-1:0]   in_data;
   modport master (output in_valid, in_addr, in_data, input in_ready);
   modport slave  (input in_valid, in_addr, in_data, output in_ready);
endinterface

// File: rtl/regbank_writeback.sv
// regbank_writeback: in-order result FIFO that drains into the regbank write port and forwards pending values.
module regbank_writeback #(
   parameter int WIDTH   = 16,
   parameter int REG_SEL = 3,
   parameter int DEPTH   = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   regbank_writeback_if.slave    push_if,
   input  logic                  hold,
   output logic                  write_enable,
   output logic [REG_SEL-1:0]    addr_z,
   output logic [WIDTH-1:0]      data_z,
   input  logic [REG_SEL-1:0]    look_addr_a,
   input  logic [REG_SEL-1:0]    look_addr_b,
   output logic                  hit_a,
   output logic                  hit_b,
   output logic [WIDTH-1:0]      fwd_a,
   output logic [WIDTH-1:0]      fwd_b,
   output logic [AW:0]           count
);
   logic [REG_SEL-1:0] mem_addr [DEPTH];
   logic [WIDTH-1:0]   mem_data [DEPTH];
   logic [AW-1:0]      rd_ptr, wr_ptr;
   logic               push, pop;
   assign push_if.in_ready = count != (AW+1)'(DEPTH);
   assign push = push_if.in_valid && push_if.in_ready;
   assign pop  = count != '0 && !hold;
   // Storage is never reset; entries outside [rd_ptr, rd_ptr+count) are masked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= push_if.in_addr;
         mem_data[wr_ptr] <= push_if.in_data;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         write_enable <= 1'b0;
         addr_z       <= '0;
         data_z       <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            addr_z <= mem_addr[rd_ptr];
            data_z <= mem_data[rd_ptr];
         end
         write_enable <= pop;
         count        <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   // Scan oldest (output stage) to newest (tail) so the youngest match overwrites.
   function automatic logic [WIDTH:0] lookup(input logic [REG_SEL-1:0] a);
      logic [WIDTH:0] r;
      logic [AW-1:0]  idx;
      r = (write_enable && addr_z == a) ? {1'b1, data_z} : '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if ((AW+1)'(i) < count && mem_addr[idx] == a) r = {1'b1, mem_data[idx]};
      end
      return r;
   endfunction
   assign {hit_a, fwd_a} = lookup(look_addr_a);
   assign {hit_b, fwd_b} = lookup(look_addr_b);
endmodule

// File: tb/tb_regbank_writeback.sv
// tb_regbank_writeback: directed vectors with hand-computed expectations for regbank_writeback.
module tb_regbank_writeback;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        hold = 1'b0;
   logic        write_enable, hit_a, hit_b;
   logic [2:0]  addr_z, look_addr_a = '0, look_addr_b = '0;
   logic [15:0] data_z, fwd_a, fwd_b;
   logic [2:0]  count;
   int          n_checks = 0;
   int          n_fail = 0;
   regbank_writeback_if #(.WIDTH(16), .REG_SEL(3)) bus ();
   regbank_writeback #(.WIDTH(16), .REG_SEL(3), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .push_if(bus.slave), .hold(hold),
      .write_enable(write_enable), .addr_z(addr_z), .data_z(data_z),
      .look_addr_a(look_addr_a), .look_addr_b(look_addr_b),
      .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [2:0] a, input logic [15:0] d);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask
   task automatic expect_write(input string tag, input logic [2:0] a, input logic [15:0] d);
      check({tag, "_we"}, 32'(write_enable), 1);
      check({tag, "_addr"}, 32'(addr_z), 32'(a));
      check({tag, "_data"}, 32'(data_z), 32'(d));
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;
      #3;
      check("rst_we", 32'(write_enable), 0);
      check("rst_count", 32'(count), 0);
      check("rst_addr", 32'(addr_z), 0);
      check("rst_data", 32'(data_z), 0);
      check("rst_ready", 32'(bus.in_ready), 1);
      tick();
      reset = 1'b1;
      // single result: write strobe one cycle after acceptance
      push(3'd2, 16'h0004);
      check("t1_count", 32'(count), 1);
      check("t1_we_early", 32'(write_enable), 0);
      tick();
      expect_write("t1", 3'd2, 16'h0004);
      check("t1_count_after", 32'(count), 0);
      tick();
      check("t1_we_drop", 32'(write_enable), 0);
      // fill while held, overflow push ignored, then drain in order
      hold = 1'b1;
      for (int i = 0; i < 4; i++) push(3'(i), 16'(i + 1));
      check("t2_count", 32'(count), 4);
      check("t2_ready", 32'(bus.in_ready), 0);
      push(3'd5, 16'h0055);
      check("t2_count_full", 32'(count), 4);
      look_addr_a = 3'd3;
      #1;
      check("t2_fwd3", 32'({hit_a, fwd_a}), 32'h10004);
      hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_write($sformatf("t2_w%0d", i), 3'(i), 16'(i + 1));
      end
      check("t2_ready_after", 32'(bus.in_ready), 1);
      check("t2_count_after", 32'(count), 0);
      tick();
      check("t2_no_extra", 32'(write_enable), 0);
      // forwarding: youngest wins, across FIFO and output stage
      hold = 1'b1;
      push(3'd1, 16'h0007);
      push(3'd1, 16'h0009);
      look_addr_a = 3'd1;
      look_addr_b = 3'd5;
      #1;
      check("t3_hit_a", 32'(hit_a), 1);
      check("t3_fwd_a", 32'(fwd_a), 32'h9);
      check("t3_hit_b", 32'(hit_b), 0);
      check("t3_fwd_b", 32'(fwd_b), 0);
      hold = 1'b0;
      tick();
      expect_write("t3_d0", 3'd1, 16'h0007);
      check("t3_fwd_mixed", 32'({hit_a, fwd_a}), 32'h10009);
      tick();
      expect_write("t3_d1", 3'd1, 16'h0009);
      check("t3_fwd_stage", 32'({hit_a, fwd_a}), 32'h10009);
      tick();
      check("t3_fwd_none", 32'({hit_a, fwd_a}), 0);
      // full FIFO: no pass-through accept on the draining edge
      hold = 1'b1;
      for (int i = 0; i < 4; i++) push(3'(4 + i), 16'(10 + i));
      hold = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_addr  = 3'd0;
      bus.in_data  = 16'd14;
      tick();
      check("t4_count_a", 32'(count), 3);
      expect_write("t4_w4", 3'd4, 16'd10);
      tick();
      bus.in_valid = 1'b0;
      check("t4_count_b", 32'(count), 3);
      expect_write("t4_w5", 3'd5, 16'd11);
      tick();
      expect_write("t4_w6", 3'd6, 16'd12);
      tick();
      expect_write("t4_w7", 3'd7, 16'd13);
      tick();
      expect_write("t4_w0", 3'd0, 16'd14);
      tick();
      check("t4_idle", 32'(write_enable), 0);
      // streaming across pointer wrap
      for (int k = 0; k < 6; k++) begin
         push(3'(k), 16'(16'h0100 + k));
         if (k > 0) expect_write($sformatf("t5_w%0d", k - 1), 3'(k - 1), 16'(16'h0100 + k - 1));
      end
      tick();
      expect_write("t5_w5", 3'd5, 16'h0105);
      tick();
      check("t5_idle", 32'(write_enable), 0);
      // async reset mid-drain
      hold = 1'b1;
      push(3'd1, 16'h0011);
      push(3'd2, 16'h0022);
      push(3'd3, 16'h0033);
      hold = 1'b0;
      tick();
      expect_write("t6_pre", 3'd1, 16'h0011);
      look_addr_a = 3'd2;
      #1;
      reset = 1'b0;
      #1;
      check("t6_we", 32'(write_enable), 0);
      check("t6_count", 32'(count), 0);
      check("t6_hit", 32'(hit_a), 0);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t6_quiet%0d", i), 32'(write_enable), 0);
      end
      push(3'd6, 16'h0066);
      tick();
      expect_write("t6_new", 3'd6, 16'h0066);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
